// File: rtl/updn_counter_pkg.sv
// Shared definitions for the multi-channel up/down counter.
package updn_counter_pkg;

  // Overflow/underflow handling modes.
  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  // Width of the signed intermediate used for count +/- step.
  // Two extra bits cover the sign and a carry of up to 2^WIDTH-1 + 2^WIDTH-1.
  function automatic int delta_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/updn_counter_ch.sv
// One counter channel: count register, net-delta arithmetic,
// wrap/saturate select and the ovf/unf pulse registers.
module updn_counter_ch
  import updn_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int INC_SIZE = 1,
  parameter int DEC_SIZE = 1,
  parameter int SATURATE = CNT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf,
  output logic             zero
);

  localparam int DW = delta_width(WIDTH);
  localparam logic signed [DW-1:0] INC_S = DW'(INC_SIZE);
  localparam logic signed [DW-1:0] DEC_S = DW'(DEC_SIZE);
  localparam logic signed [DW-1:0] MAX_S = DW'((longint'(1) << WIDTH) - 1);
  localparam bit SAT_MODE = (SATURATE == CNT_MODE_SAT);

  if (WIDTH < 2) begin : g_bad_width
    $error("updn_counter_ch: WIDTH must be >= 2");
  end
  if (INC_SIZE < 0 || longint'(INC_SIZE) >= (longint'(1) << WIDTH)) begin : g_bad_inc
    $error("updn_counter_ch: INC_SIZE must lie in 0 .. 2^WIDTH-1");
  end
  if (DEC_SIZE < 0 || longint'(DEC_SIZE) >= (longint'(1) << WIDTH)) begin : g_bad_dec
    $error("updn_counter_ch: DEC_SIZE must lie in 0 .. 2^WIDTH-1");
  end
  if (SATURATE != CNT_MODE_WRAP && SATURATE != CNT_MODE_SAT) begin : g_bad_mode
    $error("updn_counter_ch: SATURATE must be CNT_MODE_WRAP or CNT_MODE_SAT");
  end

  logic [WIDTH-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic signed [DW-1:0]    next_s;
  logic                    above_max;
  logic                    below_zero;

  // Untruncated signed sum of the current count and the requested steps.
  always_comb begin
    next_s = $signed({2'b00, count_q});
    if (inc) next_s = next_s + INC_S;
    if (dec) next_s = next_s - DEC_S;
  end

  assign above_max  = (next_s > MAX_S);
  assign below_zero = next_s[DW-1];

  // Next count and flags; load wins over any step request.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (above_max) begin
      ovf_d   = 1'b1;
      count_d = SAT_MODE ? {WIDTH{1'b1}} : next_s[WIDTH-1:0];
    end else if (below_zero) begin
      unf_d   = 1'b1;
      count_d = SAT_MODE ? {WIDTH{1'b0}} : next_s[WIDTH-1:0];
    end else begin
      count_d = next_s[WIDTH-1:0];
    end
  end

  // State register; reset discards whatever update was computed this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/updn_counter_multi.sv
// NUM_CH independent up/down counters; this level only packs/unpacks ports.
module updn_counter_multi
  import updn_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 4,
  parameter int INC_SIZE = 1,
  parameter int DEC_SIZE = 1,
  parameter int SATURATE = CNT_MODE_WRAP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       dec,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       unf,
  output logic [NUM_CH-1:0]       zero
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("updn_counter_multi: NUM_CH must be >= 1");
  end

  // One channel instance per counter, sliced out of the packed buses.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    updn_counter_ch #(
      .WIDTH    (WIDTH),
      .INC_SIZE (INC_SIZE),
      .DEC_SIZE (DEC_SIZE),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[i]),
      .dec      (dec[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .count    (count[i*WIDTH +: WIDTH]),
      .ovf      (ovf[i]),
      .unf      (unf[i]),
      .zero     (zero[i])
    );
  end

endmodule

// File: tb/tb_updn_counter_multi.sv
// Bench: three configurations (wrap 3/2, saturate 3/2, wrap 2/2) share one
// stimulus stream and are checked every cycle against an integer model.
module tb_updn_counter_multi;

  localparam int W  = 4;
  localparam int NC = 2;
  localparam int ND = 3;
  localparam int M  = 1 << W;

  localparam int INC_SZ [ND] = '{3, 3, 2};
  localparam int DEC_SZ [ND] = '{2, 2, 2};
  localparam int SAT_M  [ND] = '{0, 1, 0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] inc = '0, dec = '0, load = '0;
  logic [NC*W-1:0] load_val = '0;

  logic [NC*W-1:0] cnt_a [ND];
  logic [NC-1:0]   ovf_a [ND];
  logic [NC-1:0]   unf_a [ND];
  logic [NC-1:0]   zero_a[ND];

  int checks = 0;
  int errors = 0;
  bit started = 0;

  int m_cnt [ND][NC];
  bit m_ovf [ND][NC];
  bit m_unf [ND][NC];

  always #5 clk = ~clk;

  updn_counter_multi #(.WIDTH(W), .NUM_CH(NC), .INC_SIZE(3), .DEC_SIZE(2), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
    .count(cnt_a[0]), .ovf(ovf_a[0]), .unf(unf_a[0]), .zero(zero_a[0]));
  updn_counter_multi #(.WIDTH(W), .NUM_CH(NC), .INC_SIZE(3), .DEC_SIZE(2), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
    .count(cnt_a[1]), .ovf(ovf_a[1]), .unf(unf_a[1]), .zero(zero_a[1]));
  updn_counter_multi #(.WIDTH(W), .NUM_CH(NC), .INC_SIZE(2), .DEC_SIZE(2), .SATURATE(0)) dut_e (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
    .count(cnt_a[2]), .ovf(ovf_a[2]), .unf(unf_a[2]), .zero(zero_a[2]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int dut_cnt(input int d, input int c);
    logic [NC*W-1:0] v;
    v = cnt_a[d];
    return int'(v[c*W +: W]);
  endfunction

  // Reference model: plain integer arithmetic on the sampled inputs.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        int n;
        if (rst) begin
          m_cnt[d][c] = 0; m_ovf[d][c] = 0; m_unf[d][c] = 0;
        end else if (load[c]) begin
          m_cnt[d][c] = int'(load_val[c*W +: W]); m_ovf[d][c] = 0; m_unf[d][c] = 0;
        end else begin
          n = m_cnt[d][c] + (inc[c] ? INC_SZ[d] : 0) - (dec[c] ? DEC_SZ[d] : 0);
          m_ovf[d][c] = (n > M - 1);
          m_unf[d][c] = (n < 0);
          if (SAT_M[d] == 1 && n > M - 1) m_cnt[d][c] = M - 1;
          else if (SAT_M[d] == 1 && n < 0) m_cnt[d][c] = 0;
          else m_cnt[d][c] = ((n % M) + M) % M;
        end
      end
    end
  end

  // Every-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < NC; c++) begin
          check($sformatf("d%0d_ch%0d_count", d, c), dut_cnt(d, c), m_cnt[d][c]);
          check($sformatf("d%0d_ch%0d_ovf", d, c), int'(ovf_a[d][c]), int'(m_ovf[d][c]));
          check($sformatf("d%0d_ch%0d_unf", d, c), int'(unf_a[d][c]), int'(m_unf[d][c]));
          check($sformatf("d%0d_ch%0d_zero", d, c), int'(zero_a[d][c]), int'(m_cnt[d][c] == 0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] i, input logic [1:0] dd,
                       input logic [1:0] l, input int lv0, input int lv1);
    rst = r; inc = i; dec = dd; load = l;
    load_val = {W'(lv1), W'(lv0)};
  endtask

  initial begin
    int exp_w [6];
    int exp_s [6];
    exp_w = '{3, 6, 9, 12, 15, 2};
    exp_s = '{3, 6, 9, 12, 15, 15};

    // 1. Reset overrides inc.
    drive(1, 2'b11, 2'b00, 2'b00, 0, 0);
    tick();
    started = 1;
    check("rst_ch0", dut_cnt(0, 0), 0);
    check("rst_ch1", dut_cnt(0, 1), 0);
    check("rst_zero", int'(zero_a[0]), 3);
    check("rst_flags", int'({ovf_a[0], unf_a[0]}), 0);
    drive(0, 2'b01, 2'b00, 2'b00, 0, 0);
    tick();
    check("first_inc_ch0", dut_cnt(0, 0), 3);
    check("first_inc_ch1", dut_cnt(0, 1), 0);

    // 2. Overflow: wrap vs saturate.
    drive(1, 2'b00, 2'b00, 2'b00, 0, 0);
    tick();
    drive(0, 2'b01, 2'b00, 2'b00, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("ovf_seq_wrap_%0d", k), dut_cnt(0, 0), exp_w[k]);
      check($sformatf("ovf_seq_sat_%0d", k), dut_cnt(1, 0), exp_s[k]);
      check($sformatf("ovf_pulse_wrap_%0d", k), int'(ovf_a[0][0]), int'(k == 5));
      check($sformatf("ovf_pulse_sat_%0d", k), int'(ovf_a[1][0]), int'(k == 5));
    end
    tick();
    check("sat_hold_count", dut_cnt(1, 0), 15);
    check("sat_repulse_ovf", int'(ovf_a[1][0]), 1);
    check("wrap_after_ovf", dut_cnt(0, 0), 5);
    check("wrap_ovf_cleared", int'(ovf_a[0][0]), 0);

    // 3. Underflow on ch1.
    drive(0, 2'b00, 2'b00, 2'b10, 0, 1);
    tick();
    drive(0, 2'b00, 2'b10, 2'b00, 0, 0);
    tick();
    check("unf_wrap_count", dut_cnt(0, 1), 15);
    check("unf_wrap_flag", int'(unf_a[0][1]), 1);
    check("unf_sat_count", dut_cnt(1, 1), 0);
    check("unf_sat_flag", int'(unf_a[1][1]), 1);
    check("unf_sat_zero", int'(zero_a[1][1]), 1);
    drive(0, 2'b00, 2'b00, 2'b00, 0, 0);
    tick();
    check("unf_pulse_one_cycle", int'(unf_a[0][1]), 0);

    // 4. Simultaneous inc+dec from 5.
    drive(0, 2'b00, 2'b00, 2'b01, 5, 0);
    tick();
    drive(0, 2'b01, 2'b01, 2'b00, 0, 0);
    tick();
    check("incdec_net", dut_cnt(0, 0), 6);
    check("incdec_equal_hold", dut_cnt(2, 0), 5);
    check("incdec_equal_flags", int'({ovf_a[2][0], unf_a[2][0]}), 0);

    // 5. Load beats inc/dec.
    drive(0, 2'b00, 2'b00, 2'b01, 14, 0);
    tick();
    drive(0, 2'b01, 2'b01, 2'b01, 7, 0);
    tick();
    check("load_prio_count", dut_cnt(0, 0), 7);
    check("load_prio_flags", int'({ovf_a[0][0], unf_a[0][0]}), 0);

    // 6. Independent channels, then fully random traffic.
    for (int k = 0; k < 10; k++) begin
      drive(0, {1'b0, 1'($urandom_range(1))}, {1'($urandom_range(1)), 1'b0}, 2'b00, 0, 0);
      tick();
    end
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(31) == 0), 2'($urandom), 2'($urandom),
            (($urandom_range(7) == 0) ? 2'($urandom) : 2'b00),
            int'($urandom_range(M - 1)), int'($urandom_range(M - 1)));
      tick();
    end

    // Reset mid-run with both channels active.
    drive(0, 2'b01, 2'b10, 2'b00, 0, 0);
    tick();
    drive(1, 2'b01, 2'b10, 2'b00, 0, 0);
    tick();
    check("midrst_ch0", dut_cnt(0, 0), 0);
    check("midrst_ch1", dut_cnt(0, 1), 0);
    check("midrst_flags", int'({ovf_a[0], unf_a[0], ovf_a[1], unf_a[1]}), 0);
    drive(0, 2'b00, 2'b00, 2'b00, 0, 0);
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updn_counter_multi.md
Name: updn_counter_multi

Overview:
Multi-channel, parametrised up/down counter and the successor to the single-channel increment-only counter.
Each channel independently increments by INC_SIZE, decrements by DEC_SIZE, or parallel-loads a value.
Each channel offers wrap or saturate handling, with overflow/underflow pulses and a zero flag.
Used for event tallies, credit counting and occupancy tracking in surrounding datapath blocks.

Parameters:
WIDTH, 8, bits per channel counter (>=2).
NUM_CH, 4, number of independent channels (>=1).
INC_SIZE, 1, increment step; 0 <= INC_SIZE <= 2^WIDTH-1.
DEC_SIZE, 1, decrement step; 0 <= DEC_SIZE <= 2^WIDTH-1.
SATURATE, 0, 0 = modulo-2^WIDTH wrap; 1 = clamp at 0 / 2^WIDTH-1.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
inc  in  NUM_CH  per-channel increment request.
dec  in  NUM_CH  per-channel decrement request.
load  in  NUM_CH  per-channel parallel load.
load_val  in  NUM_CH*WIDTH  load data; channel i at bits [i*WIDTH +: WIDTH].
count  out  NUM_CH*WIDTH  registered counter values, same packing as load_val.
ovf  out  NUM_CH  registered 1-cycle pulse: step exceeded 2^WIDTH-1.
unf  out  NUM_CH  registered 1-cycle pulse: step went below 0.
zero  out  NUM_CH  combinational (count[i] == 0) from the registered count.

Behaviour:
- Reset: rst=1 at a rising edge sets all count=0 and ovf=unf=0, so zero=all ones. Reset overrides load/inc/dec in the same cycle. Reset mid-operation discards the in-flight update.
- Latency: one cycle. Inputs sampled at edge N; count/ovf/unf reflect them after edge N.
- Per-channel priority: rst > load > inc/dec.
- load[i]=1: count[i] <= load_val[i]; ovf[i]=unf[i]=0; inc[i]/dec[i] ignored that cycle.
- Net step: delta = (inc ? INC_SIZE : 0) - (dec ? DEC_SIZE : 0).
  - inc and dec together apply the net delta. If INC_SIZE == DEC_SIZE, count holds.
  - Neither asserted: count holds; ovf=unf=0.
- Arithmetic: next = count + delta, computed signed in WIDTH+2 bits; no intermediate truncation.
  - next > 2^WIDTH-1: ovf=1. SATURATE=0 gives next mod 2^WIDTH; SATURATE=1 gives 2^WIDTH-1.
  - next < 0: unf=1. SATURATE=0 gives next mod 2^WIDTH; SATURATE=1 gives 0.
  - Otherwise count <= next; ovf=unf=0.
  - ovf and unf are never both 1 for one channel in one cycle.
- A saturated counter that receives a further step in the same direction re-pulses ovf/unf every cycle while the request persists.
- Channels are fully independent; no cross-channel interaction.
- Illegal parameters (WIDTH<2, NUM_CH<1, step >= 2^WIDTH) are rejected at elaboration.

Decomposition:
- Shared package updn_counter_pkg holds:
  - mode constants CNT_MODE_WRAP=0 and CNT_MODE_SAT=1;
  - a delta-width helper function (WIDTH+2).
- One natural sub-module, updn_counter_ch:
  - a single channel holding the count register, net-delta arithmetic, wrap/saturate select and flag registers;
  - updn_counter_multi instantiates NUM_CH copies in a generate loop and handles port packing only.

Test Plan (WIDTH=4, NUM_CH=2, INC_SIZE=3, DEC_SIZE=2 unless stated):
1. Reset: drive rst=1 with inc=2'b11 for one edge -> count={0,0}, ovf=unf=0, zero=2'b11. Release rst; inc ch0 once -> ch0=3, ch1=0.
2. Overflow, SATURATE=0: inc ch0 for 6 cycles -> 3,6,9,12,15,2; ovf[0] pulses only on the 15->2 edge. SATURATE=1: 15 then 15 with ovf=1 each extra cycle.
3. Underflow: load ch1=1 then dec ch1 -> SATURATE=0: count=15, unf[1]=1 for one cycle. SATURATE=1: count=0, unf[1]=1, zero[1]=1.
4. Simultaneous inc+dec on ch0 from 5 -> 6. With INC_SIZE=DEC_SIZE=2 from 5 -> 5, no flags.
5. Load priority: ch0=14 with load=1, load_val=7, inc=1, dec=1 -> ch0=7, ovf=unf=0.
6. Independence and reset mid-run: ch0 incrementing, ch1 decrementing for 10 random cycles, compared against a reference model. Assert rst with both active -> both 0 next edge, flags cleared.
